// File: rtl/subbytes_protected_seq_pkg.sv
// Shared types and helpers for the Hamming-protected byte-serial SubBytes stage.
// The Hamming(12,8) code used by predictor and checker lives here so both agree.
package subbytes_protected_seq_pkg;

    localparam int NUM_BYTES  = 16;
    localparam int CODEWORD_W = 12;
    localparam int CHECK_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUB   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [7:0] byte_sel(input logic [127:0] st, input logic [3:0] idx);
        return st[{idx, 3'b000} +: 8];
    endfunction

    // Data-bit columns 3,5,6,7,9,10,11,12: distinct and not weight-1, so any
    // single or double codeword flip yields a nonzero syndrome.
    function automatic logic [CHECK_W-1:0] hamming_check(input logic [7:0] d);
        logic [CHECK_W-1:0] c;
        c[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return c;
    endfunction

endpackage

// File: rtl/SubBytes.sv
// AES forward S-box, purely combinational table lookup.
module SubBytes (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Row 0x0_ is the most significant 128 bits; entry x sits at byte (255-x).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/SubBytesHammingChecker.sv
// Syndrome of codeword {data[7:0], check[3:0]}; zero means consistent.
module SubBytesHammingChecker
    import subbytes_protected_seq_pkg::*;
(
    input  logic [CODEWORD_W-1:0] codeword,
    output logic [CHECK_W-1:0]    syndrome
);

    assign syndrome = hamming_check(codeword[CODEWORD_W-1:CHECK_W]) ^ codeword[CHECK_W-1:0];

endmodule

// File: rtl/SubBytesHammingPredictor.sv
// Predicts the Hamming check bits of S(x) from the input byte x, using its own
// S-box lookup so a fault in the main S-box path is not shared.
module SubBytesHammingPredictor
    import subbytes_protected_seq_pkg::*;
(
    input  logic [7:0]         in_byte,
    output logic [CHECK_W-1:0] check
);

    logic [7:0] pred_sbox;

    SubBytes u_pred_sbox (
        .in_byte  (in_byte),
        .out_byte (pred_sbox)
    );

    assign check = hamming_check(pred_sbox);

endmodule

// File: rtl/subbytes_err_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module subbytes_err_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/subbytes_protected_seq.sv
// Byte-serial SubBytes over a 128-bit state with Hamming-checked retry,
// per-byte fault reporting and a built-in fault-injection path.
module subbytes_protected_seq
    import subbytes_protected_seq_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_state,
    output logic [15:0]          out_fault,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic [11:0]          inj_mask,
    input  logic [3:0]           inj_byte,
    input  logic                 inj_persist
);

    localparam logic [3:0] MAX_R    = 4'(MAX_RETRY);
    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    state_e                state, state_nxt;
    logic [127:0]          in_reg;
    logic [3:0]            idx, retry;
    logic [CODEWORD_W-1:0] codeword, inj_xor;
    logic [7:0]            sub_in, sbox_out;
    logic [CHECK_W-1:0]    check, syndrome;
    logic                  syn_err, byte_final, err_inc;

    assign sub_in = byte_sel(in_reg, idx);

    SubBytes u_sbox (
        .in_byte  (sub_in),
        .out_byte (sbox_out)
    );

    SubBytesHammingPredictor u_pred (
        .in_byte (sub_in),
        .check   (check)
    );

    SubBytesHammingChecker u_chk (
        .codeword (codeword),
        .syndrome (syndrome)
    );

    subbytes_err_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_count)
    );

    assign syn_err    = |syndrome;
    // A byte is finished when clean or when its retry budget is spent.
    assign byte_final = !syn_err || (retry >= MAX_R);
    assign inj_xor    = ((idx == inj_byte) && (inj_persist || (retry == '0))) ? inj_mask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SUB;
            SUB:     state_nxt = CHECK;
            CHECK:   if (byte_final && (idx == LAST_IDX)) state_nxt = DONE;
                     else                                 state_nxt = SUB;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CHECK:   err_inc   = syn_err;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg    <= '0;
            out_state <= '0;
            out_fault <= '0;
            idx       <= '0;
            retry     <= '0;
            codeword  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_reg    <= in_state;
                    out_state <= '0;
                    out_fault <= '0;
                    idx       <= '0;
                    retry     <= '0;
                end
                SUB: codeword <= {sbox_out, check} ^ inj_xor;
                CHECK: begin
                    if (byte_final) begin
                        out_state[{idx, 3'b000} +: 8] <= codeword[CODEWORD_W-1:CHECK_W];
                        if (syn_err)
                            out_fault[idx] <= 1'b1;
                        retry <= '0;
                        if (idx != LAST_IDX)
                            idx <= idx + 1'b1;
                    end else begin
                        retry <= retry + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_protected_seq.sv
// Directed scoreboard bench: the driver queues hand-computed results and a
// monitor pops/compares on each output handshake.
module tb_subbytes_protected_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [15:0]  out_fault;
    logic [7:0]   err_count;
    logic [11:0]  inj_mask;
    logic [3:0]   inj_byte;
    logic         inj_persist;

    typedef struct {
        logic [127:0] st;
        logic [15:0]  fault;
        logic [7:0]   errs;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   err_model = 0;
    bit   vld_seen = 0;
    int   vld_cyc = 0;

    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] PAT_IN = {{14{8'h01}}, 8'h00, 8'h53};
    localparam logic [127:0] PAT_OUT = {{14{8'h7c}}, 8'h63, 8'hed};

    subbytes_protected_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .out_fault   (out_fault),
        .err_count   (err_count),
        .inj_mask    (inj_mask),
        .inj_byte    (inj_byte),
        .inj_persist (inj_persist)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare once per output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !vld_seen) begin
                vld_seen = 1;
                vld_cyc  = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_state", out_state, e.st);
                    chk("out_fault", out_fault, e.fault);
                    chk("err_count", err_count, e.errs);
                    chk("latency", vld_cyc - e.acc, e.lat);
                end
                vld_seen = 0;
            end
        end else begin
            vld_seen = 0;
        end
    end

    task automatic run_block(input logic [127:0] st, input logic [11:0] m, input logic [3:0] b,
                             input logic p, input logic [127:0] exp_st, input logic [15:0] exp_f,
                             input int n_err, input int lat, input bit push, input bit wait_done);
        int t;
        exp_t e;
        inj_mask    = m;
        inj_byte    = b;
        inj_persist = p;
        in_state    = st;
        in_valid    = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            err_model = (err_model + n_err > 255) ? 255 : err_model + n_err;
            e.st = exp_st; e.fault = exp_f; e.errs = 8'(err_model); e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
        if (wait_done) begin
            t = 0;
            while (sb.size() != 0 && t < 200) begin
                @(posedge clk); #1; t++;
            end
            if (sb.size() != 0) chk("done_timeout", 0, 1);
        end
    endtask

    initial begin
        logic [127:0] e;
        int t;
        rst_n = 1'b0; in_valid = 0; in_state = '0; out_ready = 1'b1;
        inj_mask = '0; inj_byte = '0; inj_persist = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_state", out_state, 0);
        chk("rst_out_fault", out_fault, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        run_block('0, '0, 4'd0, 0, ALL63, 16'h0, 0, 32, 1, 1);

        // Backpressure: result held while out_ready is low; new requests ignored.
        out_ready = 1'b0;
        run_block(PAT_IN, '0, 4'd0, 0, PAT_OUT, 16'h0, 0, 32, 1, 0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1; t++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = {4{32'hdeadbeef}};
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_state", out_state, PAT_OUT);
            chk("hold_fault", out_fault, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_hs", in_ready, 1);
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(posedge clk); #1; t++;
        end

        run_block('0, 12'h001, 4'd3, 0, ALL63, 16'h0, 1, 34, 1, 1);
        run_block('0, 12'h003, 4'd5, 1, ALL63, 16'h0020, 3, 36, 1, 1);

        for (int k = 0; k < 90; k++) begin
            e = ALL63;
            e[(k % 16) * 8 +: 8] = 8'he3;
            run_block('0, 12'h800, 4'(k % 16), 1, e, 16'(1 << (k % 16)), 3, 36, 1, 1);
        end
        chk("err_saturated", err_count, 255);

        // Reset while byte 7 is in SUB.
        run_block(PAT_IN, '0, 4'd0, 0, '0, '0, 0, 0, 0, 0);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_state", out_state, 0);
        chk("midrst_err_count", err_count, 0);
        err_model = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1);
        run_block(PAT_IN, '0, 4'd0, 0, PAT_OUT, 16'h0, 0, 32, 1, 1);

        repeat (5) @(posedge clk);
        chk("queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
